// File: rtl/pulse_gen_multi.sv
// NUM_CH independent pulse-train generators with programmable high/low width and pulse count,
// sharing one clock-enable tick. Define PULSE_GEN_MULTI_CONT_EN to make pulse_num=0 run continuously.
module pulse_gen_multi #(
  parameter int NUM_CH           = 2,
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic [NUM_CH*PULSE_NUM_BITS-1:0]   pulse_num,
  input  logic [NUM_CH*PULSE_WIDTH_BITS-1:0] high_width,
  input  logic [NUM_CH*PULSE_WIDTH_BITS-1:0] low_width,
  input  logic [NUM_CH-1:0]                  trigger,
  input  logic [NUM_CH-1:0]                  abort,
  output logic [NUM_CH-1:0]                  out,
  output logic [NUM_CH-1:0]                  done,
  output logic [NUM_CH-1:0]                  rdy,
  output logic [NUM_CH*PULSE_NUM_BITS-1:0]   pulses_done
);

  localparam int PN = PULSE_NUM_BITS;
  localparam int PW = PULSE_WIDTH_BITS;
  localparam logic [PW-1:0] W_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PN-1:0] PD_ONE = {{(PN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t        state, state_nxt;
    logic [PW-1:0] cnt, cnt_nxt, high_q, high_nxt, low_q, low_nxt;
    logic [PN-1:0] num_q, num_nxt, pd_q, pd_nxt, pd_inc;
    logic [PW-1:0] high_in, low_in;
    logic [PN-1:0] num_in;
    logic          accept, zero_job, last_pulse;
    logic          out_c, done_c, rdy_c;

    assign num_in  = pulse_num[ch*PN +: PN];
    assign high_in = high_width[ch*PW +: PW];
    assign low_in  = low_width[ch*PW +: PW];
    assign accept  = trigger[ch] & clk_en & ~abort[ch];
    assign pd_inc  = pd_q + PD_ONE;

`ifdef PULSE_GEN_MULTI_CONT_EN
    // num=0 means run forever, so a wrap of pd_inc to zero must not end the job
    assign zero_job   = (high_in == '0);
    assign last_pulse = (num_q != '0) && (pd_inc == num_q);
`else
    assign zero_job   = (num_in == '0) || (high_in == '0);
    assign last_pulse = (pd_inc == num_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        cnt    <= '0;
        high_q <= '0;
        low_q  <= '0;
        num_q  <= '0;
        pd_q   <= '0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        high_q <= high_nxt;
        low_q  <= low_nxt;
        num_q  <= num_nxt;
        pd_q   <= pd_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      high_nxt  = high_q;
      low_nxt   = low_q;
      num_nxt   = num_q;
      pd_nxt    = pd_q;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            num_nxt   = num_in;
            high_nxt  = high_in;
            low_nxt   = low_in;
            cnt_nxt   = '0;
            pd_nxt    = '0;
            state_nxt = zero_job ? DONE : HIGH;
          end
        end
        HIGH: begin
          if (abort[ch]) begin
            state_nxt = DONE;
          end else if (clk_en) begin
            if (cnt == high_q - W_ONE) begin
              cnt_nxt = '0;
              // zero low width: the pulse ends here and out stays high into the next one
              if (low_q == '0) begin
                pd_nxt    = pd_inc;
                state_nxt = last_pulse ? DONE : HIGH;
              end else begin
                state_nxt = LOW;
              end
            end else begin
              cnt_nxt = cnt + W_ONE;
            end
          end
        end
        LOW: begin
          if (abort[ch]) begin
            state_nxt = DONE;
          end else if (clk_en) begin
            if (cnt == low_q - W_ONE) begin
              cnt_nxt   = '0;
              pd_nxt    = pd_inc;
              state_nxt = last_pulse ? DONE : HIGH;
            end else begin
              cnt_nxt = cnt + W_ONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_comb begin
      out_c  = (state == HIGH);
      done_c = (state == DONE);
      rdy_c  = (state == IDLE) || (state == DONE);
    end

    assign out[ch]                 = out_c;
    assign done[ch]                = done_c;
    assign rdy[ch]                 = rdy_c;
    assign pulses_done[ch*PN +: PN] = pd_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi (NUM_CH=2, 8-bit fields); continuous-mode scenario only
// when PULSE_GEN_MULTI_CONT_EN is defined.
module tb_pulse_gen_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [15:0] pulse_num, high_width, low_width;
  logic [1:0]  trigger, abort;
  logic [1:0]  out, done, rdy;
  logic [15:0] pulses_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_gen_multi #(.NUM_CH(2), .PULSE_NUM_BITS(8), .PULSE_WIDTH_BITS(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .pulse_num(pulse_num), .high_width(high_width), .low_width(low_width),
    .trigger(trigger), .abort(abort),
    .out(out), .done(done), .rdy(rdy), .pulses_done(pulses_done)
  );

  // Advance one clock edge; inputs are then driven and outputs sampled 1ns after it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int n, input int h, input int l);
    logic [7:0] nv, hv, lv;
    nv = n[7:0]; hv = h[7:0]; lv = l[7:0];
    pulse_num[ch*8 +: 8]  = nv;
    high_width[ch*8 +: 8] = hv;
    low_width[ch*8 +: 8]  = lv;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_en = 1'b0; trigger = '0; abort = '0;
    pulse_num = '0; high_width = '0; low_width = '0;
    #3;
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL reset_out got %b want 00", out); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
    checks++; if (rdy !== 2'b11) begin errors++; $display("FAIL reset_rdy got %b want 11", rdy); end
    checks++; if (pulses_done !== 16'h0) begin errors++; $display("FAIL reset_pd got %h want 0000", pulses_done); end
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    checks++; if (rdy !== 2'b11 || out !== 2'b00) begin errors++; $display("FAIL idle_after_reset rdy=%b out=%b want 11/00", rdy, out); end
  endtask

  task automatic test_pattern();
    clk_en = 1'b1;
    set_cfg(0, 3, 2, 2);
    set_cfg(1, 0, 0, 0);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    for (int k = 0; k < 12; k++) begin
      checks++; if (out[0] !== ((k % 4) < 2)) begin errors++; $display("FAIL pattern_out0 k=%0d got %b want %b", k, out[0], ((k % 4) < 2)); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL pattern_done0 k=%0d got %b want 0", k, done[0]); end
      checks++; if (out[1] !== 1'b0 || rdy[1] !== 1'b1) begin errors++; $display("FAIL pattern_ch1 k=%0d out1=%b rdy1=%b want 0/1", k, out[1], rdy[1]); end
      cycle();
    end
    checks++; if (done[0] !== 1'b1 || out[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL pattern_end done0=%b out0=%b rdy0=%b want 1/0/1", done[0], out[0], rdy[0]); end
    checks++; if (pulses_done[7:0] !== 8'd3) begin errors++; $display("FAIL pattern_pd0 got %0d want 3", pulses_done[7:0]); end
  endtask

  task automatic test_slow_tick();
    set_cfg(1, 2, 1, 3);
    clk_en = 1'b1;
    trigger = 2'b10;
    cycle();
    trigger = 2'b00;
    for (int e = 0; e < 32; e++) begin
      clk_en = (((e + 1) % 4) == 0);
      checks++; if (out[1] !== ((e % 16) < 4)) begin errors++; $display("FAIL slow_out1 e=%0d got %b want %b", e, out[1], ((e % 16) < 4)); end
      checks++; if (done[1] !== 1'b0) begin errors++; $display("FAIL slow_done1 e=%0d got %b want 0", e, done[1]); end
      cycle();
    end
    checks++; if (done[1] !== 1'b1 || out[1] !== 1'b0) begin errors++; $display("FAIL slow_end done1=%b out1=%b want 1/0", done[1], out[1]); end
    checks++; if (pulses_done[15:8] !== 8'd2) begin errors++; $display("FAIL slow_pd1 got %0d want 2", pulses_done[15:8]); end
    for (int e = 0; e < 8; e++) begin
      clk_en = ((e % 4) == 0);
      cycle();
    end
    checks++; if (done[1] !== 1'b1 || pulses_done[15:8] !== 8'd2) begin errors++; $display("FAIL slow_hold done1=%b pd1=%0d want 1/2", done[1], pulses_done[15:8]); end
    clk_en = 1'b1;
    trigger = 2'b10;
    cycle();
    trigger = 2'b00;
    checks++; if (done[1] !== 1'b0 || out[1] !== 1'b1 || rdy[1] !== 1'b0) begin errors++; $display("FAIL retrig done1=%b out1=%b rdy1=%b want 0/1/0", done[1], out[1], rdy[1]); end
    checks++; if (pulses_done[15:8] !== 8'd0) begin errors++; $display("FAIL retrig_pd1 got %0d want 0", pulses_done[15:8]); end
    clk_en = 1'b0;
    abort = 2'b10;
    cycle();
    abort = 2'b00;
    checks++; if (done[1] !== 1'b1 || out[1] !== 1'b0) begin errors++; $display("FAIL abort_ch1 done1=%b out1=%b want 1/0", done[1], out[1]); end
  endtask

  task automatic test_full_duty();
    clk_en = 1'b1;
    set_cfg(0, 4, 3, 0);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    for (int e = 0; e < 12; e++) begin
      checks++; if (out[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL full_duty e=%0d out0=%b done0=%b want 1/0", e, out[0], done[0]); end
      if (e == 5) begin
        checks++; if (pulses_done[7:0] !== 8'd1) begin errors++; $display("FAIL full_duty_mid_pd got %0d want 1", pulses_done[7:0]); end
      end
      cycle();
    end
    checks++; if (done[0] !== 1'b1 || out[0] !== 1'b0 || pulses_done[7:0] !== 8'd4) begin errors++; $display("FAIL full_duty_end done0=%b out0=%b pd0=%0d want 1/0/4", done[0], out[0], pulses_done[7:0]); end
    // high=0 is a zero job
    set_cfg(0, 3, 0, 2);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    checks++; if (done[0] !== 1'b1 || rdy[0] !== 1'b1 || pulses_done[7:0] !== 8'd0) begin errors++; $display("FAIL zero_high done0=%b rdy0=%b pd0=%0d want 1/1/0", done[0], rdy[0], pulses_done[7:0]); end
    for (int e = 0; e < 3; e++) begin
      checks++; if (out[0] !== 1'b0) begin errors++; $display("FAIL zero_high_out e=%0d got %b want 0", e, out[0]); end
      cycle();
    end
    set_cfg(0, 1, 1, 1);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    checks++; if (out[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL short_high out0=%b done0=%b want 1/0", out[0], done[0]); end
    cycle();
    checks++; if (out[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL short_low out0=%b done0=%b want 0/0", out[0], done[0]); end
    cycle();
    checks++; if (done[0] !== 1'b1 || pulses_done[7:0] !== 8'd1) begin errors++; $display("FAIL short_end done0=%b pd0=%0d want 1/1", done[0], pulses_done[7:0]); end
`ifndef PULSE_GEN_MULTI_CONT_EN
    set_cfg(0, 0, 2, 2);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    checks++; if (done[0] !== 1'b1 || pulses_done[7:0] !== 8'd0) begin errors++; $display("FAIL zero_num done0=%b pd0=%0d want 1/0", done[0], pulses_done[7:0]); end
    for (int e = 0; e < 3; e++) begin
      checks++; if (out[0] !== 1'b0) begin errors++; $display("FAIL zero_num_out e=%0d got %b want 0", e, out[0]); end
      cycle();
    end
`endif
  endtask

  task automatic test_abort();
    clk_en = 1'b1;
    set_cfg(0, 10, 2, 2);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    for (int e = 0; e < 6; e++) cycle();
    checks++; if (out[0] !== 1'b0 || pulses_done[7:0] !== 8'd1) begin errors++; $display("FAIL abort_pre out0=%b pd0=%0d want 0/1", out[0], pulses_done[7:0]); end
    clk_en = 1'b0;
    abort = 2'b01;
    trigger = 2'b01;
    cycle();
    checks++; if (out[0] !== 1'b0 || done[0] !== 1'b1 || pulses_done[7:0] !== 8'd1) begin errors++; $display("FAIL abort_low out0=%b done0=%b pd0=%0d want 0/1/1", out[0], done[0], pulses_done[7:0]); end
    clk_en = 1'b1;
    cycle();
    checks++; if (out[0] !== 1'b0 || done[0] !== 1'b1 || pulses_done[7:0] !== 8'd1) begin errors++; $display("FAIL abort_prio out0=%b done0=%b pd0=%0d want 0/1/1", out[0], done[0], pulses_done[7:0]); end
    abort = 2'b00;
    clk_en = 1'b0;
    cycle();
    checks++; if (out[0] !== 1'b0 || done[0] !== 1'b1) begin errors++; $display("FAIL trig_no_tick out0=%b done0=%b want 0/1", out[0], done[0]); end
    trigger = 2'b00;
    clk_en = 1'b1;
    cycle();
    checks++; if (out[0] !== 1'b0 || done[0] !== 1'b1) begin errors++; $display("FAIL trig_not_stored out0=%b done0=%b want 0/1", out[0], done[0]); end
  endtask

  task automatic test_dual();
    clk_en = 1'b1;
    set_cfg(0, 2, 1, 1);
    set_cfg(1, 1, 3, 2);
    trigger = 2'b11;
    cycle();
    trigger = 2'b00;
    for (int e = 0; e < 6; e++) begin
      checks++; if (out[0] !== ((e < 4) && (e % 2 == 0)) || done[0] !== (e >= 4)) begin errors++; $display("FAIL dual_ch0 e=%0d out0=%b done0=%b want %b/%b", e, out[0], done[0], ((e < 4) && (e % 2 == 0)), (e >= 4)); end
      checks++; if (out[1] !== (e < 3) || done[1] !== (e >= 5)) begin errors++; $display("FAIL dual_ch1 e=%0d out1=%b done1=%b want %b/%b", e, out[1], done[1], (e < 3), (e >= 5)); end
      cycle();
    end
    checks++; if (pulses_done !== 16'h0102) begin errors++; $display("FAIL dual_pd got %h want 0102", pulses_done); end
    // ch1 left in DONE; ch0 restarted, then reset mid-job
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    cycle();
    checks++; if (out[0] !== 1'b0 || rdy[0] !== 1'b0 || done[1] !== 1'b1) begin errors++; $display("FAIL premid out0=%b rdy0=%b done1=%b want 0/0/1", out[0], rdy[0], done[1]); end
    cycle();
    checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL midjob_out0 got %b want 1", out[0]); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out !== 2'b00 || done !== 2'b00 || rdy !== 2'b11) begin errors++; $display("FAIL async_reset out=%b done=%b rdy=%b want 00/00/11", out, done, rdy); end
    checks++; if (pulses_done !== 16'h0) begin errors++; $display("FAIL async_reset_pd got %h want 0000", pulses_done); end
    cycle();
    reset = 1'b1;
    cycle();
    checks++; if (out !== 2'b00 || rdy !== 2'b11) begin errors++; $display("FAIL post_reset out=%b rdy=%b want 00/11", out, rdy); end
  endtask

`ifdef PULSE_GEN_MULTI_CONT_EN
  task automatic test_continuous();
    logic [7:0] exp_pd;
    clk_en = 1'b1;
    set_cfg(0, 0, 1, 1);
    trigger = 2'b01;
    cycle();
    trigger = 2'b00;
    for (int e = 0; e < 600; e++) begin
      exp_pd = 8'((e / 2) % 256);
      checks++; if (out[0] !== (e % 2 == 0) || done[0] !== 1'b0) begin errors++; $display("FAIL cont_out e=%0d out0=%b done0=%b want %b/0", e, out[0], done[0], (e % 2 == 0)); end
      checks++; if (pulses_done[7:0] !== exp_pd) begin errors++; $display("FAIL cont_pd e=%0d got %0d want %0d", e, pulses_done[7:0], exp_pd); end
      cycle();
    end
    abort = 2'b01;
    cycle();
    abort = 2'b00;
    checks++; if (done[0] !== 1'b1 || out[0] !== 1'b0) begin errors++; $display("FAIL cont_abort done0=%b out0=%b want 1/0", done[0], out[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_slow_tick();
    test_full_duty();
    test_abort();
    test_dual();
`ifdef PULSE_GEN_MULTI_CONT_EN
    test_continuous();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
Multi-channel successor to the single-channel 50%-duty pulse generator. It provides NUM_CH independent pulse trains. Each channel has its own high width, low width, pulse count, trigger, abort and status. All channels share one clock and one clock-enable tick. It sits between the motion/plot controllers and the stepper/servo pin drivers, one channel per axis or actuator.

Parameters:
NUM_CH, 2, number of independent channels
PULSE_NUM_BITS, 8, width of per-channel pulse count field
PULSE_WIDTH_BITS, 8, width of per-channel high/low width fields, counted in clk_en ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clk_en  in  1  shared timebase tick; timing advances only on cycles with clk_en=1
pulse_num  in  NUM_CH*PULSE_NUM_BITS  per-channel pulse count; channel i at [i*PULSE_NUM_BITS +: PULSE_NUM_BITS]
high_width  in  NUM_CH*PULSE_WIDTH_BITS  per-channel high time in ticks
low_width  in  NUM_CH*PULSE_WIDTH_BITS  per-channel low time in ticks
trigger  in  NUM_CH  per-channel start request
abort  in  NUM_CH  per-channel stop request
out  out  NUM_CH  pulse outputs
done  out  NUM_CH  job finished; held until next accepted trigger
rdy  out  NUM_CH  channel accepts a trigger
pulses_done  out  NUM_CH*PULSE_NUM_BITS  per-channel count of completed pulses

Behaviour:
- Channels are fully independent. The spec below applies to each channel i.
- Reset is asynchronous and active-low. On reset: state IDLE, out=0, done=0, rdy=1, pulses_done=0, latched config=0, counters=0.
- The FSM has four states: IDLE, HIGH, LOW, DONE.
- Outputs are decoded from registered state:
  - out=1 only in HIGH.
  - rdy=1 in IDLE and DONE.
  - done=1 only in DONE.
- Trigger acceptance: trigger=1, rdy=1, clk_en=1 and abort=0 on the same edge.
  - Latch pulse_num, high_width, low_width; clear width counter and pulses_done.
  - If latched num=0 or high=0 (zero job): go to DONE directly; out never rises.
  - Otherwise go to HIGH. out rises the cycle after the accepting edge.
- A trigger with clk_en=0 is ignored and is not stored.
- HIGH, on each clk_en:
  - If width_cnt==high-1: clear width_cnt and leave HIGH; otherwise increment width_cnt.
  - If low=0 (100% duty, out stays 1 across pulses), the end of HIGH completes the pulse and applies the pulse-end rule below.
  - If low>0, go to LOW.
- LOW, on each clk_en: if width_cnt==low-1, clear width_cnt and complete the pulse; otherwise increment width_cnt.
- Pulse-end rule: increment pulses_done. If the new value equals num, go to DONE; otherwise go to HIGH.
- Job length is exactly num*(high+low) clk_en ticks. done rises the cycle after the final tick.
- Width counters are PULSE_WIDTH_BITS wide. Maximum high or low is 2^PULSE_WIDTH_BITS-1 ticks; there is no wrap.
- DONE holds out=0, done=1, rdy=1 and the final pulses_done value until the next accepted trigger.
- Abort: abort=1 in HIGH or LOW goes to DONE on the next edge regardless of clk_en.
  - out drops the next cycle; pulses_done is frozen at the completed-pulse count.
  - Abort in IDLE or DONE does nothing.
  - Abort has priority over a same-cycle trigger; that trigger is dropped.
- Config inputs are sampled only at trigger acceptance. Changes mid-job have no effect.
- Asserting reset mid-job forces out=0 immediately (asynchronous) and returns the channel to IDLE.

Optional Feature:
- Macro: PULSE_GEN_MULTI_CONT_EN.
- Defined: pulse_num=0 with high>0 starts continuous mode.
  - The channel alternates HIGH/LOW indefinitely.
  - pulses_done increments and wraps modulo 2^PULSE_NUM_BITS.
  - Only abort or reset ends the job; abort goes to DONE as usual.
- Not defined: pulse_num=0 is a zero job, going straight to DONE with out=0, and the continuous-mode logic is absent.

Test Plan:
- Reset, then NUM_CH=2, clk_en every cycle, ch0 num=3 high=2 low=2, single trigger pulse -> out0 pattern 1100 1100 1100; done0 rises exactly 12 cycles after out0 first rises; pulses_done0=3; ch1 stays out=0, rdy=1.
- clk_en every 4th cycle, ch1 num=2 high=1 low=3 -> out1 high for 4 clk cycles, low for 12, repeated twice; done1 held until retrigger, which clears done1 and pulses_done1.
- ch0 num=4 high=3 low=0 -> out0 high for 12 contiguous ticks, then done0; trigger with num=0 (macro off) or high=0 -> done the next cycle, out never 1.
- ch0 num=10 high=2 low=2, abort asserted during the 2nd LOW with clk_en=0 -> out0=0 and done0=1 the next cycle, pulses_done0=1; a same-cycle trigger is ignored.
- Both channels triggered on the same edge with different configs -> independent, exact timing on both; reset pulled low mid-job -> out, done and pulses_done clear immediately, rdy=1.
- With PULSE_GEN_MULTI_CONT_EN defined, ch0 num=0 high=1 low=1, run 600 ticks -> continuous square wave, pulses_done wraps 255 to 0; abort -> done0=1.
